// File: rtl/fifo_burst_reader.sv
// Burst read master: issues one bus read command, streams beats into the pixel FIFO.
// Optional FIFO_BURST_READER_BYTE_SWAP_EN byte-reverses each word written to the FIFO.
module fifo_burst_reader #(
    parameter int BURST_WORDS = 64,
    parameter int BURST_BYTES = 256
) (
    input  logic        Bus2IP_Clk,
    input  logic        Bus2IP_Resetn,
    input  logic        go_fill_fifo,
    input  logic [31:0] ddr_addr_to_read,
    input  logic        clr_status,
    output logic        ip2bus_mstrd_req,
    output logic [31:0] ip2bus_mst_addr,
    output logic [11:0] ip2bus_mst_length,
    input  logic        bus2ip_mst_cmdack,
    input  logic        bus2ip_mst_cmplt,
    input  logic        bus2ip_mst_error,
    input  logic [31:0] bus2ip_mstrd_d,
    input  logic        bus2ip_mstrd_src_rdy_n,
    output logic        ip2bus_mstrd_dst_rdy_n,
    output logic        fifo_wr_en,
    output logic [31:0] fifo_wr_data,
    input  logic        fifo_full,
    output logic        busy,
    output logic        overrun,
    output logic        rd_error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DATA,
        S_WAIT
    } state_t;

    localparam logic [8:0] LAST = 9'(BURST_WORDS - 1);

    state_t      r_state;
    state_t      w_next;
    logic [8:0]  r_cnt;
    logic [31:0] r_addr;
    logic        r_overrun;
    logic        r_rd_error;
    logic        w_beat;
    logic        w_last;
    logic        w_early;
    logic        w_ovr_set;
    logic        w_err_set;
    logic [31:0] w_data;

`ifdef FIFO_BURST_READER_BYTE_SWAP_EN
    assign w_data = {bus2ip_mstrd_d[7:0], bus2ip_mstrd_d[15:8],
                     bus2ip_mstrd_d[23:16], bus2ip_mstrd_d[31:24]};
`else
    assign w_data = bus2ip_mstrd_d;
`endif

    assign w_beat = (r_state == S_DATA) && !bus2ip_mstrd_src_rdy_n && !fifo_full;
    assign w_last = (r_cnt == LAST);

    always_comb begin
        w_next  = r_state;
        w_early = 1'b0;
        unique case (r_state)
            S_IDLE: if (go_fill_fifo) w_next = S_REQ;
            S_REQ:  if (bus2ip_mst_cmdack) w_next = S_DATA;
            S_DATA: begin
                if (w_beat && w_last) begin
                    w_next = bus2ip_mst_cmplt ? S_IDLE : S_WAIT;
                end else if (bus2ip_mst_cmplt) begin
                    // completion before the last beat means a short burst
                    w_next  = S_IDLE;
                    w_early = 1'b1;
                end
            end
            S_WAIT: if (bus2ip_mst_cmplt) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_ovr_set = go_fill_fifo && (r_state != S_IDLE);
    assign w_err_set = (bus2ip_mst_error && (r_state != S_IDLE)) || w_early;

    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_overrun  <= 1'b0;
            r_rd_error <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && go_fill_fifo) begin
                r_addr <= ddr_addr_to_read;
                r_cnt  <= '0;
            end else if (w_beat) begin
                r_cnt <= r_cnt + 9'd1;
            end
            if (w_ovr_set)       r_overrun <= 1'b1;
            else if (clr_status) r_overrun <= 1'b0;
            if (w_err_set)       r_rd_error <= 1'b1;
            else if (clr_status) r_rd_error <= 1'b0;
        end
    end

    always_comb begin
        ip2bus_mstrd_dst_rdy_n = 1'b1;
        if (r_state == S_DATA)      ip2bus_mstrd_dst_rdy_n = fifo_full;
        else if (r_state == S_WAIT) ip2bus_mstrd_dst_rdy_n = 1'b0;
    end

    assign ip2bus_mstrd_req  = (r_state == S_REQ);
    assign ip2bus_mst_addr   = r_addr;
    assign ip2bus_mst_length = 12'(BURST_BYTES);
    assign fifo_wr_en        = w_beat;
    assign fifo_wr_data      = w_beat ? w_data : 32'd0;
    assign busy              = (r_state != S_IDLE);
    assign overrun           = r_overrun;
    assign rd_error          = r_rd_error;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: full bursts, stalls, overrun,
// short/error bursts, mid-burst reset and byte ordering.
module tb_fifo_burst_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic [31:0] ddr_addr = '0;
    logic        clr = 1'b0;
    logic        req;
    logic [31:0] maddr;
    logic [11:0] mlen;
    logic        cmdack = 1'b0;
    logic        cmplt = 1'b0;
    logic        merr = 1'b0;
    logic [31:0] rd_d = '0;
    logic        src_rdy_n = 1'b1;
    logic        dst_rdy_n;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        full = 1'b0;
    logic        busy;
    logic        overrun;
    logic        rd_error;

    int n_chk = 0;
    int n_err = 0;
    int req_cycles = 0;
    logic [31:0] wq[$];

    fifo_burst_reader #(.BURST_WORDS(64), .BURST_BYTES(256)) dut (
        .Bus2IP_Clk             (clk),
        .Bus2IP_Resetn          (rst_n),
        .go_fill_fifo           (go),
        .ddr_addr_to_read       (ddr_addr),
        .clr_status             (clr),
        .ip2bus_mstrd_req       (req),
        .ip2bus_mst_addr        (maddr),
        .ip2bus_mst_length      (mlen),
        .bus2ip_mst_cmdack      (cmdack),
        .bus2ip_mst_cmplt       (cmplt),
        .bus2ip_mst_error       (merr),
        .bus2ip_mstrd_d         (rd_d),
        .bus2ip_mstrd_src_rdy_n (src_rdy_n),
        .ip2bus_mstrd_dst_rdy_n (dst_rdy_n),
        .fifo_wr_en             (wr_en),
        .fifo_wr_data           (wr_data),
        .fifo_full              (full),
        .busy                   (busy),
        .overrun                (overrun),
        .rd_error               (rd_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) wq.push_back(wr_data);
        if (req) req_cycles++;
    end

    function automatic logic [31:0] exp_d(input logic [31:0] x);
`ifdef FIFO_BURST_READER_BYTE_SWAP_EN
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
        return x;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic [31:0] a);
        req_cycles = 0;
        go = 1'b1;
        ddr_addr = a;
        tick();
        go = 1'b0;
        repeat (3) tick();
        cmdack = 1'b1;
        tick();
        cmdack = 1'b0;
    endtask

    task automatic beats(input int lo, input int hi, input int stall_at);
        for (int i = lo; i <= hi; i++) begin
            rd_d = 32'(i);
            src_rdy_n = 1'b0;
            if (i == stall_at) begin
                full = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    #1;
                    chk("stall_dst", {31'd0, dst_rdy_n}, 32'd1);
                    chk("stall_wr", {31'd0, wr_en}, 32'd0);
                    tick();
                end
                full = 1'b0;
            end
            tick();
        end
        src_rdy_n = 1'b1;
    endtask

    task automatic finish_wait();
        cmplt = 1'b1;
        tick();
        cmplt = 1'b0;
    endtask

    task automatic check_order(input string tag, input int n);
        int bad;
        bad = 0;
        foreach (wq[k]) if (wq[k] !== exp_d(32'(k))) bad++;
        chk({tag, "_cnt"}, 32'(wq.size()), 32'(n));
        chk({tag, "_order"}, 32'(bad), 32'd0);
    endtask

    initial begin
        #3;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_dst", {31'd0, dst_rdy_n}, 32'd1);
        chk("rst_wr", {31'd0, wr_en}, 32'd0);
        chk("rst_data", wr_data, 32'd0);
        chk("rst_addr", maddr, 32'd0);
        chk("rst_flags", {30'd0, overrun, rd_error}, 32'd0);
        chk("len", {20'd0, mlen}, 32'd256);
        tick();
        rst_n = 1'b1;
        tick();

        // plain 64-beat burst, then a dropped beat in WAIT_CMPLT
        wq.delete();
        start_cmd(32'h1000_0000);
        chk("t1_addr", maddr, 32'h1000_0000);
        chk("t1_reqcyc", 32'(req_cycles), 32'd4);
        chk("t1_req_lo", {31'd0, req}, 32'd0);
        beats(0, 63, -1);
        chk("t1_wait_busy", {31'd0, busy}, 32'd1);
        chk("t1_wait_dst", {31'd0, dst_rdy_n}, 32'd0);
        rd_d = 32'hDEAD_BEEF;
        src_rdy_n = 1'b0;
        #1;
        chk("t1_drop", {31'd0, wr_en}, 32'd0);
        tick();
        src_rdy_n = 1'b1;
        finish_wait();
        chk("t1_idle", {31'd0, busy}, 32'd0);
        check_order("t1", 64);

        // FIFO full stalls five cycles at beat 10
        wq.delete();
        start_cmd(32'h1000_4000);
        beats(0, 63, 10);
        finish_wait();
        chk("t2_idle", {31'd0, busy}, 32'd0);
        check_order("t2", 64);

        // go during DATA, with clr in the same cycle: set wins
        wq.delete();
        start_cmd(32'h2000_0000);
        beats(0, 4, -1);
        go = 1'b1;
        clr = 1'b1;
        ddr_addr = 32'h3000_0000;
        tick();
        go = 1'b0;
        clr = 1'b0;
        chk("t3_ovr", {31'd0, overrun}, 32'd1);
        chk("t3_addr", maddr, 32'h2000_0000);
        beats(5, 63, -1);
        finish_wait();
        chk("t3_reqcyc", 32'(req_cycles), 32'd4);
        chk("t3_idle", {31'd0, busy}, 32'd0);
        check_order("t3", 64);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t3_clr", {31'd0, overrun}, 32'd0);

        // error together with cmplt after beat 20
        wq.delete();
        start_cmd(32'h4000_0000);
        beats(0, 20, -1);
        merr = 1'b1;
        cmplt = 1'b1;
        tick();
        merr = 1'b0;
        cmplt = 1'b0;
        chk("t4_err", {31'd0, rd_error}, 32'd1);
        chk("t4_idle", {31'd0, busy}, 32'd0);
        check_order("t4", 21);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t4_clr", {31'd0, rd_error}, 32'd0);

        // early cmplt alone still flags rd_error
        start_cmd(32'h4100_0000);
        beats(0, 2, -1);
        finish_wait();
        chk("t4b_err", {31'd0, rd_error}, 32'd1);
        chk("t4b_idle", {31'd0, busy}, 32'd0);
        clr = 1'b1;
        tick();
        clr = 1'b0;

        // reset at beat 30
        start_cmd(32'h5000_0000);
        beats(0, 29, -1);
        rd_d = 32'd30;
        src_rdy_n = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_wr", {31'd0, wr_en}, 32'd0);
        chk("t5_dst", {31'd0, dst_rdy_n}, 32'd1);
        chk("t5_data", wr_data, 32'd0);
        chk("t5_addr", maddr, 32'd0);
        chk("t5_req", {31'd0, req}, 32'd0);
        src_rdy_n = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        go = 1'b1;
        ddr_addr = 32'h6000_0000;
        tick();
        go = 1'b0;
        chk("t5_newreq", {31'd0, req}, 32'd1);
        chk("t5_newaddr", maddr, 32'h6000_0000);
        cmdack = 1'b1;
        tick();
        cmdack = 1'b0;

        // byte order, and final beat coinciding with cmplt
        rd_d = 32'h1122_3344;
        src_rdy_n = 1'b0;
        #1;
        chk("t6_swap", wr_data, exp_d(32'h1122_3344));
        tick();
        beats(1, 62, -1);
        rd_d = 32'd63;
        src_rdy_n = 1'b0;
        cmplt = 1'b1;
        tick();
        src_rdy_n = 1'b1;
        cmplt = 1'b0;
        chk("t6_idle", {31'd0, busy}, 32'd0);
        chk("t6_noerr", {31'd0, rd_error}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter BURST_WORDS, default 64, meaning 32-bit words per burst (legal 2..256).
REQ-002 SHALL have parameter BURST_BYTES, default 256, meaning ip2bus_mst_length value (BURST_WORDS*4).
REQ-003 SHALL have ports: Bus2IP_Clk  in  1  system clock, all logic on rising edge.
REQ-004 Bus2IP_Resetn  in  1  asynchronous, active-low reset.
REQ-005 go_fill_fifo  in  1  one-cycle burst start pulse from the fill-FIFO controller.
REQ-006 ddr_addr_to_read  in  32  burst byte start address, sampled with go_fill_fifo.
REQ-007 clr_status  in  1  synchronous clear of sticky flags.
REQ-008 ip2bus_mstrd_req  out  1  read command request.
REQ-009 ip2bus_mst_addr  out  32  latched command address.
REQ-010 ip2bus_mst_length  out  12  burst length in bytes, constant BURST_BYTES.
REQ-011 bus2ip_mst_cmdack  in  1  command accepted.
REQ-012 bus2ip_mst_cmplt  in  1  transfer complete.
REQ-013 bus2ip_mst_error  in  1  transfer error.
REQ-014 bus2ip_mstrd_d  in  32  read data.
REQ-015 bus2ip_mstrd_src_rdy_n  in  1  read data valid, active low.
REQ-016 ip2bus_mstrd_dst_rdy_n  out  1  reader ready, active low.
REQ-017 fifo_wr_en  out  1  pixel FIFO write strobe.
REQ-018 fifo_wr_data  out  32  pixel FIFO write data.
REQ-019 fifo_full  in  1  pixel FIFO full.
REQ-020 busy  out  1  high whenever state is not IDLE.
REQ-021 overrun  out  1  sticky: go_fill_fifo arrived while busy.
REQ-022 rd_error  out  1  sticky: bus2ip_mst_error seen.

Function
REQ-023 SHALL implement states IDLE, REQ, DATA, WAIT_CMPLT.
REQ-024 IDLE: on go_fill_fifo, latch ddr_addr_to_read into ip2bus_mst_addr, clear beat counter, go to REQ next cycle.
REQ-025 REQ: ip2bus_mstrd_req high for the whole state; on bus2ip_mst_cmdack go to DATA, with req low from the next cycle.
REQ-026 In DATA, ip2bus_mstrd_dst_rdy_n SHALL equal fifo_full (combinational).
REQ-027 A beat is defined as src_rdy_n==0 and dst_rdy_n==0 in DATA.
REQ-028 On a beat: fifo_wr_en=1 and fifo_wr_data=bus2ip_mstrd_d in the same cycle (zero latency); beat counter +1.
REQ-029 fifo_full high stalls the beat; no data is lost or duplicated.
REQ-030 Beat BURST_WORDS-1 accepted: go to WAIT_CMPLT; if cmplt is also high that cycle, go straight to IDLE.
REQ-031 WAIT_CMPLT: dst_rdy_n=0; extra beats are dropped (no fifo_wr_en); on cmplt go to IDLE.
REQ-032 cmplt in DATA before the final beat: go to IDLE and set rd_error.
REQ-033 bus2ip_mst_error in any non-IDLE state sets rd_error; the FSM still waits for cmplt.
REQ-034 go_fill_fifo while state is not IDLE, including the cycle cmplt is seen: ignored and overrun set.
REQ-035 clr_status clears overrun and rd_error; a set event in the same cycle wins.
REQ-036 Outside DATA and WAIT_CMPLT, dst_rdy_n=1 and fifo_wr_en=0.
REQ-037 The beat counter SHALL be 9 bits and SHALL never wrap within a burst.

Reset
REQ-038 Bus2IP_Resetn low SHALL set, asynchronously: state=IDLE, req=0, ip2bus_mst_addr=0, counter=0, dst_rdy_n=1, fifo_wr_en=0, fifo_wr_data=0, busy=0, overrun=0, rd_error=0.
REQ-039 Reset mid-burst SHALL abandon the burst; the first go_fill_fifo after reset release starts a fresh command.

Configuration
REQ-040 Macro FIFO_BURST_READER_BYTE_SWAP_EN defined: fifo_wr_data = bus2ip_mstrd_d byte-reversed ([7:0],[15:8],[23:16],[31:24]).
REQ-041 Macro FIFO_BURST_READER_BYTE_SWAP_EN undefined: fifo_wr_data = bus2ip_mstrd_d unchanged; no other difference.

Verification
REQ-042 go with addr 0x1000_0000, cmdack after 3 cycles, 64 back-to-back beats 0..63, then cmplt -> mst_addr=0x1000_0000, req high 4 cycles, 64 fifo writes in order, then IDLE.
REQ-043 fifo_full high for beats 10-14 -> dst_rdy_n high those cycles; FIFO receives exactly 64 words in sequence.
REQ-044 go pulsed during DATA -> overrun=1, no second command; clr_status -> overrun=0.
REQ-045 error with cmplt after beat 20 -> rd_error=1, 21 writes, IDLE next cycle.
REQ-046 Resetn low at beat 30 -> all outputs at reset values immediately; next go issues a new req.
REQ-047 With BYTE_SWAP_EN, beat 0x11223344 -> fifo_wr_data=0x44332211.
